spi_reg_target: RTL and testbench
=================================

# spi_reg_target

SPI target (responder) with a 32 x 8 register file: the target-side counterpart of the SoC's `spi0` SPI master. The Nios II drives `spi0_SCLK`, `spi0_MOSI` and `spi0_SS_n` into it, and it returns data on `spi0_MISO`. It uses the same command-byte framing as the USB host controller. Fabric logic gets a second, parallel port onto the same registers, so software and hardware can exchange control and status bytes over the existing SPI pins.

## Interface
Parameters:
- none. The register count is fixed at 32 and the width at 8 bits.

Ports:
- `Clk` in 1: system clock (50 MHz). It is the only clock.
- `Reset` in 1: synchronous, active-high.
- `SCLK` in 1: SPI clock from the master, asynchronous to `Clk`. Mode 0 (CPOL=0, CPHA=0).
- `SS_n` in 1: active-low select, asynchronous.
- `MOSI` in 1: master-to-target data, MSB first.
- `MISO` out 1: target-to-master data, MSB first. Driven 0 while not selected.
- `status` in 8: byte returned to the master during the command byte.
- `host_addr` in 5: fabric register address.
- `host_we` in 1: fabric write enable.
- `host_wdata` in 8: fabric write data.
- `host_rdata` out 8: `reg[host_addr]`, registered with 1-cycle latency.
- `spi_wr` out 1: one-cycle pulse for each register written over SPI.
- `spi_wr_addr` out 5: address of the SPI write. Valid with `spi_wr`.
- `busy` out 1: high while a transaction is in progress (state not IDLE).

## Operation
- **Synchronisers.** `SCLK`, `SS_n` and `MOSI` each pass through 2-flop synchronisers. Rising and falling edges of SCLK and SS_n are detected from the synchronised values.
- **Command byte** (first byte after SS_n falls):
  - bits [7:3] are the register address;
  - bit 1 = 1 selects write, 0 selects read;
  - bits 2 and 0 are ignored.
- **States.** IDLE → CMD → DATA.
  - IDLE → CMD on a synchronised SS_n fall. At the same time: `tx_sh` ← `status`, bit count `cnt` ← 0, `rx_sh` is cleared.
  - CMD → DATA on the 8th SCLK rise. The address and direction are latched.
    - Read: `tx_sh` ← `reg[addr]`.
    - Write: `tx_sh` ← 0x00.
  - Any synchronised SS_n rise → IDLE from any state. A partial byte is discarded, no write occurs and `MISO` goes to 0.
- **Bit timing.**
  - Each SCLK rise: `rx_sh` ← {`rx_sh[6:0]`, MOSI}, `cnt` ← `cnt` + 1 (mod 8).
  - Each SCLK fall: `tx_sh` shifts left by one, but only if `cnt` ≠ 0. There is no shift on the fall that directly follows a byte boundary, because the freshly loaded MSB must stay on `MISO`.
  - `MISO` = `tx_sh[7]` while selected.
- **Data byte complete** (8th rise while in DATA):
  - Write: `reg[addr]` ← byte; pulse `spi_wr` with `spi_wr_addr` = addr; then addr ← addr + 1 mod 32.
  - Read: addr ← addr + 1 mod 32; `tx_sh` ← `reg[addr+1]`.
  - Bursts wrap from 31 to 0.
- **Collision.** If an SPI write and `host_we` target the same address in the same cycle, SPI wins. Writes to different addresses both take effect.
- **Read ordering.** `host_rdata` reflects a write one cycle after that write. The value loaded into `tx_sh` for an SPI read is taken from the register array as it stood at the previous clock edge.

## Timing
- The SCLK high and low phases must each be ≥ 4 `Clk` periods, i.e. f_SCLK ≤ `Clk`/8.
- SS_n falling to the first SCLK rise must be ≥ 4 `Clk` periods. `MISO` shows `status[7]` within 3 `Clk` of SS_n falling.
- `MISO` updates within 3 `Clk` of an SCLK edge, either a fall or a byte-boundary load.
- `spi_wr` asserts 3 `Clk` after the SCLK rise that completes the byte; the register updates on the same edge.
- Reset values:
  - state IDLE, `busy` 0, `MISO` 0, `spi_wr` 0, `spi_wr_addr` 0, `host_rdata` 0x00;
  - all registers 0x00; `cnt`, `tx_sh`, `rx_sh` all 0.
- Reset asserted mid-transaction forces IDLE. The block then waits for a fresh SS_n fall; the SCLK edges left over from the interrupted transaction are ignored.

## Test plan
- **Single write.** SPI 0x12, 0xA5 (write reg 2). Required: exactly one `spi_wr` pulse with addr 2; `host_addr`=2 then gives `host_rdata` 0xA5; `MISO` during the command byte equals `status` (drive 0x3C).
- **Burst write with wrap.** 0xFA, 0x11, 0x22 (write from reg 31). Required: reg31=0x11, reg0=0x22, two `spi_wr` pulses with addresses 31 then 0.
- **Burst read.** Host-preload reg5=0x5A and reg6=0xC3, then SPI 0x28, 0x00, 0x00. Required: `MISO` bytes 0x3C (status), 0x5A, 0xC3; no `spi_wr`.
- **Abort mid-byte.** 0x12 followed by only 5 bits, then SS_n high. Required: no `spi_wr`, reg2 unchanged, `busy` back to 0, `MISO` 0; the next full transaction works.
- **Collision.** `host_we` to reg 2 with 0x77 in the same cycle as the SPI write 0x99 to reg 2. Required: reg2 = 0x99.
- **Reset mid-transaction.** Pulse `Reset` after 3 data bits. Required: all outputs at their reset values, reg file cleared, remaining SCLK edges ignored until SS_n toggles.

Source files
------------

// File: rtl/spi_reg_target.sv
// SPI mode-0 target with a 32 x 8 register file.
// A second fabric port reads and writes the same registers.
module spi_reg_target (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] status,
  input  logic [4:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       spi_wr,
  output logic [4:0] spi_wr_addr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sclk_s;
  logic [2:0]  r_ss_s;
  logic [1:0]  r_mosi_s;
  logic [2:0]  r_cnt;
  logic [7:0]  r_tx_sh;
  logic [7:0]  r_rx_sh;
  logic [4:0]  r_addr;
  logic        r_wr;
  logic        r_spi_wr;
  logic [4:0]  r_spi_wr_addr;
  logic [7:0]  r_host_rdata;
  logic [7:0]  r_regs [32];

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_mosi;
  logic [7:0]  w_byte;
  logic        w_done;
  logic        w_spi_we;
  logic [4:0]  w_addr_nxt;

  // Two-flop synchronisers plus one history flop for edge detection.
  // SS_n resets low so a select held low through reset is not a fall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sclk_s <= 3'b000;
      r_ss_s   <= 3'b000;
      r_mosi_s <= 2'b00;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], SCLK};
      r_ss_s   <= {r_ss_s[1:0], SS_n};
      r_mosi_s <= {r_mosi_s[0], MOSI};
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_ss_fall   = ~r_ss_s[1] & r_ss_s[2];
  assign w_ss_rise   = r_ss_s[1] & ~r_ss_s[2];
  assign w_mosi      = r_mosi_s[1];

  assign w_byte     = {r_rx_sh[6:0], w_mosi};
  assign w_done     = w_sclk_rise && (r_cnt == 3'd7);
  assign w_addr_nxt = r_addr + 5'd1;
  assign w_spi_we   = (r_state == DATA) && r_wr && w_done && !w_ss_rise;

  // Transaction FSM: bit counting, shift registers and burst address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_cnt         <= 3'd0;
      r_tx_sh       <= 8'h00;
      r_rx_sh       <= 8'h00;
      r_addr        <= 5'd0;
      r_wr          <= 1'b0;
      r_spi_wr      <= 1'b0;
      r_spi_wr_addr <= 5'd0;
    end else begin
      r_spi_wr <= 1'b0;
      if (w_ss_rise) begin
        r_state <= IDLE;
        r_cnt   <= 3'd0;
        r_tx_sh <= 8'h00;
        r_rx_sh <= 8'h00;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_ss_fall) begin
              r_state <= CMD;
              r_tx_sh <= status;
              r_cnt   <= 3'd0;
              r_rx_sh <= 8'h00;
            end
          end
          CMD, DATA: begin
            if (w_sclk_rise) begin
              r_rx_sh <= w_byte;
              r_cnt   <= r_cnt + 3'd1;
            end else if (w_sclk_fall && r_cnt != 3'd0) begin
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
            if (w_done) begin
              if (r_state == CMD) begin
                r_state <= DATA;
                r_addr  <= w_byte[7:3];
                r_wr    <= w_byte[1];
                r_tx_sh <= w_byte[1] ? 8'h00 : r_regs[w_byte[7:3]];
              end else begin
                r_addr <= w_addr_nxt;
                if (r_wr) begin
                  r_spi_wr      <= 1'b1;
                  r_spi_wr_addr <= r_addr;
                  r_tx_sh       <= 8'h00;
                end else begin
                  r_tx_sh <= r_regs[w_addr_nxt];
                end
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Register file; an SPI write beats a fabric write to the same address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      if (host_we && !(w_spi_we && host_addr == r_addr)) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_spi_we) begin
        r_regs[r_addr] <= w_byte;
      end
    end
  end

  // Fabric read port with one cycle of latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_host_rdata <= 8'h00;
    end else begin
      r_host_rdata <= r_regs[host_addr];
    end
  end

  assign MISO        = (r_state != IDLE) & r_tx_sh[7];
  assign busy        = (r_state != IDLE);
  assign spi_wr      = r_spi_wr;
  assign spi_wr_addr = r_spi_wr_addr;
  assign host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: SPI master model,
// fabric port accesses and spi_wr pulse logging.
module tb_spi_reg_target;

  localparam int HALF = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       SCLK;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [7:0] status;
  logic [4:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       spi_wr;
  logic [4:0] spi_wr_addr;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  logic [4:0] wr_log [64];

  spi_reg_target dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .SCLK        (SCLK),
    .SS_n        (SS_n),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .status      (status),
    .host_addr   (host_addr),
    .host_we     (host_we),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .spi_wr      (spi_wr),
    .spi_wr_addr (spi_wr_addr),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  // Log every spi_wr pulse cycle and its address.
  always @(negedge Clk) begin
    if (spi_wr === 1'b1) begin
      if (n_wr < 64) wr_log[n_wr] = spi_wr_addr;
      n_wr = n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits,
                      input bit coll, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      repeat (HALF) @(negedge Clk);
      rx = {rx[6:0], MISO};
      SCLK = 1'b1;
      if (coll && i == 0) begin
        repeat (2) @(negedge Clk);
        host_addr  = 5'd2;
        host_wdata = 8'h77;
        host_we    = 1'b1;
        @(negedge Clk);
        host_we = 1'b0;
        repeat (HALF - 3) @(negedge Clk);
      end else begin
        repeat (HALF) @(negedge Clk);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge Clk);
    SS_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic hwrite(input logic [4:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge Clk);
    host_we = 1'b0;
  endtask

  task automatic hread(input logic [4:0] a, output logic [7:0] d);
    host_addr = a;
    repeat (2) @(negedge Clk);
    d = host_rdata;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] rd;
    int base;

    Reset      = 1'b1;
    SCLK       = 1'b0;
    SS_n       = 1'b1;
    MOSI       = 1'b0;
    status     = 8'h3C;
    host_addr  = 5'd0;
    host_we    = 1'b0;
    host_wdata = 8'h00;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_miso", {7'd0, MISO}, 8'h00);
    check("rst_spi_wr", {7'd0, spi_wr}, 8'h00);
    check("rst_wr_addr", {3'd0, spi_wr_addr}, 8'h00);
    check("rst_rdata", host_rdata, 8'h00);

    // Single write of 0xA5 to reg 2.
    base = n_wr;
    ss_low();
    check("t1_busy", {7'd0, busy}, 8'h01);
    check("t1_miso_first", {7'd0, MISO}, 8'h00);
    xfer(8'h12, 8, 1'b0, rx);
    check("t1_cmd_miso", rx, 8'h3C);
    xfer(8'hA5, 8, 1'b0, rx);
    check("t1_data_miso", rx, 8'h00);
    ss_high();
    check("t1_busy_end", {7'd0, busy}, 8'h00);
    check("t1_nwr", 8'(n_wr - base), 8'd1);
    check("t1_wr_addr", {3'd0, wr_log[base]}, 8'd2);
    hread(5'd2, rd);
    check("t1_reg2", rd, 8'hA5);

    // Burst write starting at reg 31, wrapping to reg 0.
    base = n_wr;
    ss_low();
    xfer(8'hFA, 8, 1'b0, rx);
    xfer(8'h11, 8, 1'b0, rx);
    xfer(8'h22, 8, 1'b0, rx);
    ss_high();
    check("t2_nwr", 8'(n_wr - base), 8'd2);
    check("t2_addr0", {3'd0, wr_log[base]}, 8'd31);
    check("t2_addr1", {3'd0, wr_log[base + 1]}, 8'd0);
    hread(5'd31, rd);
    check("t2_reg31", rd, 8'h11);
    hread(5'd0, rd);
    check("t2_reg0", rd, 8'h22);

    // Burst read of regs 5 and 6 after fabric preload.
    hwrite(5'd5, 8'h5A);
    hwrite(5'd6, 8'hC3);
    base = n_wr;
    ss_low();
    xfer(8'h28, 8, 1'b0, rx);
    check("t3_status", rx, 8'h3C);
    xfer(8'h00, 8, 1'b0, rx);
    check("t3_reg5", rx, 8'h5A);
    xfer(8'h00, 8, 1'b0, rx);
    check("t3_reg6", rx, 8'hC3);
    ss_high();
    check("t3_nwr", 8'(n_wr - base), 8'd0);

    // Abort after 5 data bits.
    base = n_wr;
    ss_low();
    xfer(8'h12, 8, 1'b0, rx);
    xfer(8'hFF, 5, 1'b0, rx);
    ss_high();
    check("t4_nwr", 8'(n_wr - base), 8'd0);
    check("t4_busy", {7'd0, busy}, 8'h00);
    check("t4_miso", {7'd0, MISO}, 8'h00);
    hread(5'd2, rd);
    check("t4_reg2", rd, 8'hA5);
    ss_low();
    xfer(8'h1A, 8, 1'b0, rx);
    xfer(8'h3E, 8, 1'b0, rx);
    ss_high();
    check("t4_next_nwr", 8'(n_wr - base), 8'd1);
    check("t4_next_addr", {3'd0, wr_log[base]}, 8'd3);
    hread(5'd3, rd);
    check("t4_reg3", rd, 8'h3E);

    // SPI and fabric write reg 2 in the same cycle.
    base = n_wr;
    ss_low();
    xfer(8'h12, 8, 1'b0, rx);
    xfer(8'h99, 8, 1'b1, rx);
    ss_high();
    check("t5_nwr", 8'(n_wr - base), 8'd1);
    hread(5'd2, rd);
    check("t5_reg2", rd, 8'h99);

    // Reset after 3 data bits; leftover edges must be ignored.
    base = n_wr;
    status = 8'hC1;
    ss_low();
    xfer(8'h12, 8, 1'b0, rx);
    check("t6_status", rx, 8'hC1);
    xfer(8'hE7, 3, 1'b0, rx);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("t6_busy", {7'd0, busy}, 8'h00);
    check("t6_miso", {7'd0, MISO}, 8'h00);
    check("t6_spi_wr", {7'd0, spi_wr}, 8'h00);
    check("t6_wr_addr", {3'd0, spi_wr_addr}, 8'h00);
    check("t6_rdata", host_rdata, 8'h00);
    xfer(8'hFF, 5, 1'b0, rx);
    check("t6_busy_left", {7'd0, busy}, 8'h00);
    ss_high();
    check("t6_nwr", 8'(n_wr - base), 8'd0);
    hread(5'd2, rd);
    check("t6_reg2", rd, 8'h00);
    hread(5'd31, rd);
    check("t6_reg31", rd, 8'h00);
    ss_low();
    xfer(8'h3A, 8, 1'b0, rx);
    check("t6_new_status", rx, 8'hC1);
    xfer(8'h42, 8, 1'b0, rx);
    ss_high();
    check("t6_new_nwr", 8'(n_wr - base), 8'd1);
    check("t6_new_addr", {3'd0, wr_log[base]}, 8'd7);
    hread(5'd7, rd);
    check("t6_reg7", rd, 8'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
